// File: rtl/i2c_master.sv
// I2C register-access master: one register write or one register read (with repeated START)
// per command. SCL is timed purely from an internal quarter-period counter.
module i2c_master #(
  parameter int unsigned QDIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic [7:0] rdata,
  output logic       done,
  output logic       ack_err,
  output logic       busy
);

  if (QDIV < 2 || QDIV > 4095) begin : g_bad_qdiv
    $error("QDIV out of range 2..4095");
  end

  localparam int unsigned CntW = $clog2(QDIV);
  localparam logic [CntW-1:0] QMax = CntW'(QDIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddrW, StAck1, StReg, StAck2, StWdata, StAck3,
    StRstart, StAddrR, StAck4, StRdata, StMnack, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ack_err_q, ack_err_d;
  logic            done_q, done_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;

  logic            rw_q;
  logic [6:0]      addr_q;
  logic [7:0]      reg_q;
  logic [7:0]      wdata_q;

  logic            accept;
  logic            qtr_end;
  logic            sample;
  logic            slot_end;
  logic [2:0]      last_qtr;
  logic            is_byte;
  logic            is_ack;
  logic [7:0]      tx_byte;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;

  // Repeated START has an extra leading SCL-low quarter to release SDA first.
  assign last_qtr = (state_q == StRstart) ? 3'd4 : 3'd3;
  assign qtr_end  = (cnt_q == QMax);
  assign sample   = qtr_end && (qtr_q == 3'd1);
  assign slot_end = qtr_end && (qtr_q == last_qtr);
  assign is_byte  = (state_q == StAddrW) || (state_q == StReg) || (state_q == StWdata) ||
                    (state_q == StAddrR) || (state_q == StRdata);
  assign is_ack   = (state_q == StAck1) || (state_q == StAck2) || (state_q == StAck3) ||
                    (state_q == StAck4);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (state_q == StIdle) begin
      cnt_d = '0;
      qtr_d = 3'd0;
      if (cmd_valid) begin
        state_d   = StStart;
        bit_d     = 3'd7;
        ack_err_d = 1'b0;
      end
    end else begin
      cnt_d = qtr_end ? '0 : cnt_q + CntW'(1);
      if (qtr_end) begin
        qtr_d = (qtr_q == last_qtr) ? 3'd0 : qtr_q + 3'd1;
      end
      if (sample) begin
        if (is_ack && sda_i) begin
          ack_err_d = 1'b1;
        end
        if (state_q == StRdata) begin
          rdata_d = {rdata_q[6:0], sda_i};
        end
      end
      if (slot_end) begin
        if (is_byte && (bit_q != 3'd0)) begin
          bit_d = bit_q - 3'd1;
        end else begin
          bit_d = 3'd7;
          // ack_err_q already reflects this slot's sample, taken at the end of quarter 1.
          unique case (state_q)
            StStart:  state_d = StAddrW;
            StAddrW:  state_d = StAck1;
            StAck1:   state_d = ack_err_q ? StStop : StReg;
            StReg:    state_d = StAck2;
            StAck2:   state_d = ack_err_q ? StStop : (rw_q ? StRstart : StWdata);
            StWdata:  state_d = StAck3;
            StAck3:   state_d = StStop;
            StRstart: state_d = StAddrR;
            StAddrR:  state_d = StAck4;
            StAck4:   state_d = ack_err_q ? StStop : StRdata;
            StRdata:  state_d = StMnack;
            StMnack:  state_d = StStop;
            StStop: begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
            default:  state_d = StIdle;
          endcase
        end
      end
    end
  end

  // Line drives are computed from next state so the outputs come straight from flops.
  always_comb begin
    tx_byte = 8'hFF;
    unique case (state_d)
      StAddrW: tx_byte = {addr_q, 1'b0};
      StReg:   tx_byte = reg_q;
      StWdata: tx_byte = wdata_q;
      StAddrR: tx_byte = {addr_q, 1'b1};
      default: tx_byte = 8'hFF;
    endcase

    scl_d = 1'b0;
    sda_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      StStart: begin
        scl_d = 1'b0;
        sda_d = (qtr_d >= 3'd2);
      end
      StRstart: begin
        scl_d = (qtr_d == 3'd0);
        sda_d = (qtr_d >= 3'd3);
      end
      StStop: begin
        scl_d = (qtr_d == 3'd0);
        sda_d = (qtr_d <= 3'd2);
      end
      default: begin
        // ACK, RDATA and MNACK see tx_byte = 0xFF and so release SDA.
        scl_d = (qtr_d == 3'd0) || (qtr_d == 3'd3);
        sda_d = ~tx_byte[bit_d];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= 3'd0;
      bit_q     <= 3'd0;
      rdata_q   <= 8'h00;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else if (accept) begin
      rw_q    <= cmd_rw;
      addr_q  <= cmd_addr;
      reg_q   <= cmd_reg;
      wdata_q <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: a bus monitor decodes START/STOP/bytes from the line drives,
// and a small slave model supplies ACKs and read data.
module tb_i2c_master;

  localparam int QDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;
  logic [7:0] rdata;
  logic       done;
  logic       ack_err;
  logic       busy;

  i2c_master #(.QDIV(QDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_reg   (cmd_reg),
    .cmd_wdata (cmd_wdata),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i),
    .rdata     (rdata),
    .done      (done),
    .ack_err   (ack_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus only)
  logic       mon_en = 1'b0;
  logic       rd_mode = 1'b0;
  logic [2:0] ack_en = 3'b111;
  logic [7:0] rd_byte = 8'h00;

  // Monitor state (written by the monitor only)
  int         frame = 0;
  int         bit_idx = 0;
  int         starts = 0;
  int         stops = 0;
  int         width_err = 0;
  int         hi_len = 0;
  int         lo_len = 0;
  logic       in_xfer = 1'b0;
  logic       sampled = 1'b0;
  logic       start_in_high = 1'b1;
  logic       low_after_start = 1'b1;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic       scl_now;
  logic       sda_now;
  logic [7:0] cur = 8'h00;
  logic [7:0] mbytes[$];
  logic       macks[$];
  logic       pull;

  always_comb begin
    pull = 1'b0;
    if (mon_en && in_xfer) begin
      if (bit_idx == 8 && frame < 3) pull = ack_en[frame];
      else if (rd_mode && frame == 3 && bit_idx < 8) pull = ~rd_byte[3'(7 - bit_idx)];
    end
  end

  assign sda_i = ~sda_oe & ~pull;

  always @(negedge clk) begin
    scl_now = ~scl_oe;
    sda_now = sda_i;
    if (!mon_en) begin
      frame = 0;
      bit_idx = 0;
      in_xfer = 1'b0;
      sampled = 1'b0;
      start_in_high = 1'b1;
      low_after_start = 1'b1;
    end else begin
      if (scl_prev && scl_now && (sda_now != sda_prev)) begin
        if (!sda_now) begin
          starts++;
          if (!in_xfer) frame = 0;
          in_xfer = 1'b1;
          bit_idx = 0;
          sampled = 1'b0;
          start_in_high = 1'b1;
        end else begin
          stops++;
          in_xfer = 1'b0;
        end
      end
      if (scl_now != scl_prev) begin
        if (scl_now) begin
          if (!low_after_start && lo_len != 2 * QDIV) width_err++;
          low_after_start = 1'b0;
          hi_len = 1;
          if (in_xfer) begin
            if (bit_idx < 8) cur = {cur[6:0], sda_now};
            else begin
              mbytes.push_back(cur);
              macks.push_back(sda_now);
            end
            sampled = 1'b1;
          end
        end else begin
          if (!start_in_high && hi_len != 2 * QDIV) width_err++;
          low_after_start = start_in_high;
          start_in_high = 1'b0;
          lo_len = 1;
          if (sampled) begin
            sampled = 1'b0;
            if (bit_idx == 8) begin
              bit_idx = 0;
              frame++;
            end else bit_idx++;
          end
        end
      end else if (scl_now) hi_len++;
      else lo_len++;
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  int lat, ndone, ready_bad, ready_at_done;
  int base, s0, p0, w0;

  // Issues one command; optionally holds cmd_valid with scrambled fields for `hold` cycles.
  task automatic run_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                         input logic [7:0] wd, input int hold);
    int n;
    base = mbytes.size();
    s0 = starts;
    p0 = stops;
    w0 = width_err;
    @(negedge clk);
    cmd_rw = rw;
    cmd_addr = addr;
    cmd_reg = rg;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (hold == 0) cmd_valid = 1'b0;
    else begin
      cmd_rw = ~rw;
      cmd_addr = ~addr;
      cmd_reg = ~rg;
      cmd_wdata = ~wd;
    end
    n = 1;
    lat = -1;
    ndone = 0;
    ready_bad = 0;
    ready_at_done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n - 1;
          ready_at_done = (cmd_ready && !busy) ? 1 : 0;
        end
      end else if (lat < 0 && cmd_ready) ready_bad++;
      if (n == hold) cmd_valid = 1'b0;
      if (lat >= 0 && n > lat + 20) break;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);

    // Register write, all ACKed
    run_cmd(1'b0, 7'h29, 8'h80, 8'h03, 0);
    check("wr_latency", lat, 464);
    check("wr_done_cnt", ndone, 1);
    check("wr_ready_at_done", ready_at_done, 1);
    check("wr_ready_early", ready_bad, 0);
    check("wr_ack_err", ack_err, 0);
    check("wr_nbytes", mbytes.size() - base, 3);
    check("wr_b0", mbytes[base], 8'h52);
    check("wr_b1", mbytes[base+1], 8'h80);
    check("wr_b2", mbytes[base+2], 8'h03);
    check("wr_ack2", macks[base+2], 0);
    check("wr_starts", starts - s0, 1);
    check("wr_stops", stops - p0, 1);
    check("wr_scl_width", width_err - w0, 0);

    // Register read, slave returns 0xA5
    rd_mode = 1'b1;
    rd_byte = 8'hA5;
    run_cmd(1'b1, 7'h29, 8'h14, 8'h00, 0);
    check("rd_latency", lat, 628);
    check("rd_done_cnt", ndone, 1);
    check("rd_nbytes", mbytes.size() - base, 4);
    check("rd_b0", mbytes[base], 8'h52);
    check("rd_b1", mbytes[base+1], 8'h14);
    check("rd_b2", mbytes[base+2], 8'h53);
    check("rd_b3", mbytes[base+3], 8'hA5);
    check("rd_master_nack", macks[base+3], 1);
    check("rd_starts", starts - s0, 2);
    check("rd_stops", stops - p0, 1);
    check("rd_rdata", rdata, 8'hA5);
    check("rd_ack_err", ack_err, 0);
    check("rd_scl_width", width_err - w0, 0);
    rd_mode = 1'b0;

    // Address NACK
    ack_en = 3'b110;
    run_cmd(1'b0, 7'h29, 8'h80, 8'h03, 0);
    check("nack_latency", lat, 176);
    check("nack_done_cnt", ndone, 1);
    check("nack_nbytes", mbytes.size() - base, 1);
    check("nack_ack_bit", macks[base], 1);
    check("nack_ack_err", ack_err, 1);
    check("nack_stops", stops - p0, 1);
    check("nack_scl_width", width_err - w0, 0);
    ack_en = 3'b111;

    // cmd_valid held with new values during a transfer
    run_cmd(1'b0, 7'h15, 8'h3C, 8'hC6, 200);
    check("hold_ready_early", ready_bad, 0);
    check("hold_done_cnt", ndone, 1);
    check("hold_ack_err", ack_err, 0);
    check("hold_nbytes", mbytes.size() - base, 3);
    check("hold_b0", mbytes[base], 8'h2A);
    check("hold_b1", mbytes[base+1], 8'h3C);
    check("hold_b2", mbytes[base+2], 8'hC6);

    // Reset during RDATA bit 3, then a fresh write
    begin
      int found;
      rd_mode = 1'b1;
      rd_byte = 8'h5A;
      @(negedge clk);
      cmd_rw = 1'b1;
      cmd_addr = 7'h29;
      cmd_reg = 8'h14;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        #1;
        if (frame == 3 && bit_idx == 3) begin
          found = 1;
          break;
        end
      end
      check("abort_reached", found, 1);
      check("abort_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_scl_oe", scl_oe, 0);
      check("abort_sda_oe", sda_oe, 0);
      check("abort_busy", busy, 0);
      mon_en = 1'b0;
      rd_mode = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_rdata", rdata, 8'h00);
      mon_en = 1'b1;
      @(negedge clk);
    end
    run_cmd(1'b0, 7'h4B, 8'h01, 8'hFF, 0);
    check("post_latency", lat, 464);
    check("post_nbytes", mbytes.size() - base, 3);
    check("post_b0", mbytes[base], 8'h96);
    check("post_b1", mbytes[base+1], 8'h01);
    check("post_b2", mbytes[base+2], 8'hFF);
    check("post_ack_err", ack_err, 0);
    check("post_stops", stops - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
